// File: rtl/rtc_calendar_if.sv
// rtl/rtc_calendar_if.sv - date update, day tick, alarm and status signals of the calendar stage
interface rtc_calendar_if;
  logic        day_tick_i;
  logic        date_update_i;
  logic [31:0] date_i;
  logic        alarm_en_i;
  logic [2:0]  alarm_mask_i;
  logic [31:0] alarm_date_i;
  logic [31:0] date_o;
  logic        leap_o;
  logic        update_err_o;
  logic        date_match_o;

  modport master (
    output day_tick_i, date_update_i, date_i, alarm_en_i, alarm_mask_i, alarm_date_i,
    input  date_o, leap_o, update_err_o, date_match_o
  );

  modport slave (
    input  day_tick_i, date_update_i, date_i, alarm_en_i, alarm_mask_i, alarm_date_i,
    output date_o, leap_o, update_err_o, date_match_o
  );
endinterface

// File: rtl/rtc_calendar.sv
// rtl/rtc_calendar.sv - Gregorian year/month/day register with day advance, validated writes and date alarm
module rtc_calendar #(
  parameter logic [31:0] RESET_DATE = 32'h07D0_0101,
  parameter int unsigned MAX_YEAR   = 9999
) (
  input logic          clk_i,
  input logic          rst_i,
  rtc_calendar_if.slave bus
);

  localparam logic [13:0] MAX_Y       = 14'(MAX_YEAR);
  localparam logic [13:0] RESET_YEAR  = RESET_DATE[29:16];
  localparam logic [4:0]  RESET_MONTH = RESET_DATE[12:8];
  localparam logic [5:0]  RESET_DAY   = RESET_DATE[5:0];

  function automatic logic is_leap(input logic [13:0] y);
    return (y[1:0] == 2'b00) &&
           (((y % 14'd100) != 14'd0) || ((y % 14'd400) == 14'd0));
  endfunction

  function automatic logic [5:0] days_in_month(input logic [4:0] m, input logic leap);
    case (m)
      5'd2:                     return leap ? 6'd29 : 6'd28;
      5'd4, 5'd6, 5'd9, 5'd11:  return 6'd30;
      default:                  return 6'd31;
    endcase
  endfunction

  logic [13:0] year_q;
  logic [4:0]  month_q;
  logic [5:0]  day_q;
  logic        err_q;
  logic        match_q;

  logic [13:0] wr_year;
  logic [4:0]  wr_month;
  logic [5:0]  wr_day;
  logic        wr_valid;
  logic        cur_leap;

  logic [13:0] nxt_year;
  logic [4:0]  nxt_month;
  logic [5:0]  nxt_day;
  logic        changed;
  logic        fields_match;

  logic        unused_ok;
  assign unused_ok = ^{bus.date_i[31:30], bus.date_i[15:13], bus.date_i[7:6],
                       bus.alarm_date_i[31:30], bus.alarm_date_i[15:13], bus.alarm_date_i[7:6]};

  assign cur_leap = is_leap(year_q);

  always_comb begin
    wr_year   = bus.date_i[29:16];
    wr_month  = bus.date_i[12:8];
    wr_day    = bus.date_i[5:0];
    // Month length of a write depends on the written year's leap status.
    wr_valid  = (wr_month >= 5'd1) && (wr_month <= 5'd12) &&
                (wr_day >= 6'd1) &&
                (wr_day <= days_in_month(wr_month, is_leap(wr_year))) &&
                (wr_year <= MAX_Y);

    nxt_year  = year_q;
    nxt_month = month_q;
    nxt_day   = day_q;

    if (bus.date_update_i && wr_valid) begin
      nxt_year  = wr_year;
      nxt_month = wr_month;
      nxt_day   = wr_day;
    end else if (bus.day_tick_i) begin
      if (day_q < days_in_month(month_q, cur_leap)) begin
        nxt_day = day_q + 6'd1;
      end else if (month_q < 5'd12) begin
        nxt_day   = 6'd1;
        nxt_month = month_q + 5'd1;
      end else begin
        nxt_day   = 6'd1;
        nxt_month = 5'd1;
        nxt_year  = (year_q == MAX_Y) ? 14'd0 : year_q + 14'd1;
      end
    end

    changed      = {nxt_year, nxt_month, nxt_day} != {year_q, month_q, day_q};
    fields_match = (bus.alarm_mask_i[0] || (nxt_day   == bus.alarm_date_i[5:0]))  &&
                   (bus.alarm_mask_i[1] || (nxt_month == bus.alarm_date_i[12:8])) &&
                   (bus.alarm_mask_i[2] || (nxt_year  == bus.alarm_date_i[29:16]));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      year_q  <= RESET_YEAR;
      month_q <= RESET_MONTH;
      day_q   <= RESET_DAY;
      err_q   <= 1'b0;
      match_q <= 1'b0;
    end else begin
      year_q  <= nxt_year;
      month_q <= nxt_month;
      day_q   <= nxt_day;
      err_q   <= bus.date_update_i && !wr_valid;
      // Alarm is evaluated against the value being loaded so the pulse lines up with it.
      match_q <= changed && fields_match && bus.alarm_en_i;
    end
  end

  assign bus.date_o       = {2'b00, year_q, 3'b000, month_q, 2'b00, day_q};
  assign bus.leap_o       = cur_leap;
  assign bus.update_err_o = err_q;
  assign bus.date_match_o = match_q;

endmodule
